// File: rtl/note_oscillator.sv
// Key-driven tone oscillator: runs a per-note phase counter and periodically
// presents a stable phase/divisor pair with a one-cycle strobe for a divider.
module note_oscillator #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned SAMPLE_PERIOD = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [12:0]      key_in,
    input  logic [1:0]       octave,
    output logic             sample_now,
    output logic [CNT_W-1:0] oscillator_out,
    output logic [CNT_W-1:0] divisor_out,
    output logic             note_active
);
    localparam int unsigned NUM_KEYS = 13;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned OCT_W    = 2;
    localparam int unsigned BASE_W   = 16;
    localparam int unsigned TICK_W   = $clog2(SAMPLE_PERIOD);

    // Base period divisors for C4..C5 at the lowest octave setting.
    function automatic logic [BASE_W-1:0] base_div(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0:    return 16'd38222;
            4'd1:    return 16'd36076;
            4'd2:    return 16'd34052;
            4'd3:    return 16'd32141;
            4'd4:    return 16'd30338;
            4'd5:    return 16'd28635;
            4'd6:    return 16'd27027;
            4'd7:    return 16'd25511;
            4'd8:    return 16'd24079;
            4'd9:    return 16'd22727;
            4'd10:   return 16'd21452;
            4'd11:   return 16'd20248;
            4'd12:   return 16'd19111;
            default: return 16'd38222;
        endcase
    endfunction

    logic                sel_valid;
    logic [IDX_W-1:0]    sel_idx;
    logic [OCT_W-1:0]    sel_oct;
    logic [CNT_W-1:0]    phase_cnt;
    logic [TICK_W-1:0]   tick_cnt;

    logic                nxt_valid;
    logic [IDX_W-1:0]    nxt_idx;
    logic [OCT_W-1:0]    nxt_oct;
    logic [CNT_W-1:0]    cur_div;
    logic [CNT_W-1:0]    nxt_div;
    logic                sel_change;
    logic                tick_wrap;
    logic [CNT_W-1:0]    phase_nxt;

    // Lowest asserted key wins; octave is zeroed with no key so the tuple stays canonical.
    always_comb begin
        nxt_valid = |key_in;
        nxt_idx   = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_in[i]) begin
                nxt_idx = IDX_W'(i);
            end
        end
        nxt_oct = nxt_valid ? octave : '0;
    end

    always_comb begin
        cur_div    = CNT_W'(base_div(sel_idx) >> sel_oct);
        nxt_div    = CNT_W'(base_div(nxt_idx) >> nxt_oct);
        sel_change = (nxt_valid != sel_valid) || (nxt_idx != sel_idx) || (nxt_oct != sel_oct);
        tick_wrap  = (tick_cnt == TICK_W'(SAMPLE_PERIOD - 1));
        phase_nxt  = '0;
        if (!sel_change && sel_valid && (phase_cnt != cur_div - CNT_W'(1))) begin
            phase_nxt = phase_cnt + CNT_W'(1);
        end
    end

    // A selection change on a tick edge restarts the phase, so the strobe reports 0
    // with the newly selected divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_valid      <= 1'b0;
            sel_idx        <= '0;
            sel_oct        <= '0;
            phase_cnt      <= '0;
            tick_cnt       <= '0;
            sample_now     <= 1'b0;
            oscillator_out <= '0;
            divisor_out    <= CNT_W'(1);
            note_active    <= 1'b0;
        end else begin
            sel_valid  <= nxt_valid;
            sel_idx    <= nxt_idx;
            sel_oct    <= nxt_oct;
            phase_cnt  <= phase_nxt;
            tick_cnt   <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
            sample_now <= tick_wrap;
            if (tick_wrap) begin
                oscillator_out <= (sel_change || !sel_valid) ? '0 : phase_cnt;
                note_active    <= nxt_valid;
                if (nxt_valid) begin
                    divisor_out <= nxt_div;
                end
            end
        end
    end
endmodule

// File: tb/tb_note_oscillator.sv
// Scoreboard bench for note_oscillator: a time-based reference model predicts each
// strobe sample; a negedge monitor checks strobes and held outputs every cycle.
module tb_note_oscillator;
    localparam int CNT_W  = 16;
    localparam int PERIOD = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic [12:0]      key_in;
    logic [1:0]       octave;
    logic             sample_now;
    logic [CNT_W-1:0] oscillator_out;
    logic [CNT_W-1:0] divisor_out;
    logic             note_active;

    note_oscillator #(.CNT_W(CNT_W), .SAMPLE_PERIOD(PERIOD)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .octave(octave),
        .sample_now(sample_now), .oscillator_out(oscillator_out),
        .divisor_out(divisor_out), .note_active(note_active)
    );

    always #50 clk = ~clk;

    typedef struct {
        int osc;
        int div;
        bit active;
    } sample_t;

    sample_t exp_q[$];
    sample_t hold;
    bit      armed = 1'b0;
    int      vectors = 0;
    int      miscompares = 0;
    int      base_tab[13] = '{38222, 36076, 34052, 32141, 30338, 28635, 27027,
                              25511, 24079, 22727, 21452, 20248, 19111};

    // Reference state: note index (-1 = none), octave, edges since the last phase restart.
    int m_tick = 0, m_age = 0, m_idx = -1, m_oct = 0, m_held_div = 1;

    function automatic int lowest_key(input logic [12:0] k);
        for (int i = 0; i < 13; i++) if (k[i]) return i;
        return -1;
    endfunction

    function automatic int eff_div(input int idx, input int oct);
        return base_tab[idx] >> oct;
    endfunction

    task automatic check_vec(input string name, input bit strobe, input sample_t e);
        vectors++;
        if (sample_now !== strobe || oscillator_out !== 16'(e.osc) ||
            divisor_out !== 16'(e.div) || note_active !== e.active) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL %s t=%0t: got strobe=%0b osc=%0d div=%0d act=%0b, want strobe=%0b osc=%0d div=%0d act=%0b",
                         name, $time, sample_now, oscillator_out, divisor_out, note_active,
                         strobe, e.osc, e.div, e.active);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, got, want);
        end
    endtask

    // Reference model: phase is simply (edges since restart) mod divisor.
    always @(posedge clk) begin
        int      ni, no;
        bit      change;
        sample_t s;
        if (rst) begin
            m_tick = 0; m_age = 0; m_idx = -1; m_oct = 0; m_held_div = 1;
            exp_q.delete();
            hold  = '{0, 1, 1'b0};
            armed = 1'b1;
        end else begin
            ni     = lowest_key(key_in);
            no     = (ni < 0) ? 0 : int'(octave);
            change = (ni != m_idx) || (no != m_oct);
            if (m_tick == PERIOD - 1) begin
                s.osc = (change || m_idx < 0) ? 0 : m_age % eff_div(m_idx, m_oct);
                if (ni >= 0) m_held_div = eff_div(ni, no);
                s.div    = m_held_div;
                s.active = (ni >= 0);
                exp_q.push_back(s);
            end
            m_tick = (m_tick + 1) % PERIOD;
            m_age  = (change || ni < 0) ? 0 : m_age + 1;
            m_idx  = ni;
            m_oct  = no;
        end
    end

    // Monitor: a strobe must appear exactly when predicted; otherwise outputs hold.
    always @(negedge clk) begin
        sample_t s;
        if (armed) begin
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                check_vec("strobe", 1'b1, s);
                hold = s;
            end else begin
                check_vec("hold", 1'b0, hold);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int len;
        rst = 1'b1; key_in = '0; octave = '0;
        run(2);
        rst = 1'b0;
        check_val("reset_osc", int'(oscillator_out), 0);
        check_val("reset_div", int'(divisor_out), 1);
        check_val("reset_act", int'(note_active), 0);
        run(300);

        key_in = 13'h200;
        run(24000);
        check_val("a4_div", int'(divisor_out), 22727);
        octave = 2'd2;
        run(3000);
        check_val("a4_oct2_div", int'(divisor_out), 5681);
        octave = 2'd0;
        key_in = 13'h210;
        run(1000);
        check_val("priority_div", int'(divisor_out), 30338);

        key_in = 13'h200;
        run(600 + int'($urandom_range(0, 200)));
        key_in = 13'h1000;
        run(600);
        check_val("c5_div", int'(divisor_out), 19111);

        key_in = '0;
        run(600);
        check_val("release_div", int'(divisor_out), 19111);
        check_val("release_act", int'(note_active), 0);
        run(77);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        check_val("midreset_div", int'(divisor_out), 1);
        run(300);

        for (int seg = 0; seg < 40; seg++) begin
            case ($urandom_range(0, 3))
                0:       key_in = '0;
                1:       key_in = 13'($urandom);
                default: key_in = 13'(1) << $urandom_range(0, 12);
            endcase
            octave = 2'($urandom_range(0, 3));
            len = int'($urandom_range(20, 700));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                run(1);
                rst = 1'b0;
            end
            run(len);
        end
        run(PERIOD + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
